// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared state encodings, default widths and sel clamp
// for the divided-clock scheduler.
package clk_div_pkg;

    localparam int CNT_W_DEF = 5;
    localparam int SEL_W_DEF = 3;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t PEND = 2'd2;

    // Selects past the counter's top bit collapse onto the slowest ratio.
    function automatic int unsigned clamp_sel(
        input int unsigned sel,
        input int unsigned cnt_w
    );
        if (sel >= cnt_w)
            return cnt_w - 1;
        return sel;
    endfunction

endpackage

// File: rtl/clk_div_phase.sv
// clk_div_phase: free-running period counter with boundary detect
// and registered div_clk / div_tick outputs.
module clk_div_phase
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    input  logic [SEL_W-1:0] sel,
    output logic             div_clk,
    output logic             div_tick,
    output logic             is_boundary
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] mask;

    assign half    = {{(CNT_W-1){1'b0}}, 1'b1} << sel;
    assign mask    = half | (half - 1'b1);
    assign cnt_nxt = cnt + 1'b1;

    // Last high cycle of the period: cnt[sel:0] all ones.
    assign is_boundary = run && ((cnt & mask) == mask);

    always_ff @(posedge clk) begin
        if (!rst || clear || !run) begin
            cnt      <= '0;
            div_clk  <= 1'b0;
            div_tick <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            div_clk  <= |(cnt_nxt & half);
            div_tick <= ((cnt_nxt & mask) == half);
        end
    end

endmodule

// File: rtl/clk_div_sched.sv
// clk_div_sched: run/ratio FSM with valid/ready config handshake;
// all ratio and run changes land on a period boundary.
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SEL_W       = SEL_W_DEF,
    parameter int DEFAULT_SEL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [SEL_W-1:0] cfg_sel,
    output logic             cfg_ready,
    output logic             div_clk,
    output logic             div_tick,
    output logic [SEL_W-1:0] active_sel,
    output logic             busy
);

    localparam logic [SEL_W-1:0] RST_SEL =
        SEL_W'(clamp_sel(DEFAULT_SEL, CNT_W));

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] pending_sel;
    logic [SEL_W-1:0] act_nxt;
    logic [SEL_W-1:0] pend_nxt;
    logic [SEL_W-1:0] cfg_clamped;
    logic             accept;
    logic             clear;
    logic             boundary;

    assign cfg_ready   = rst && (state != PEND);
    assign accept      = cfg_valid && cfg_ready;
    assign cfg_clamped = SEL_W'(clamp_sel(32'(cfg_sel), CNT_W));
    assign busy        = (state != IDLE);

    always_comb begin
        state_nxt = state;
        act_nxt   = active_sel;
        pend_nxt  = pending_sel;
        clear     = 1'b0;
        unique case (1'b1)
            (state == IDLE): begin
                if (accept)
                    act_nxt = cfg_clamped;
                if (en)
                    state_nxt = RUN;
            end
            (state == RUN): begin
                if (boundary && !en) begin
                    // Stop; a config taken on this edge still lands.
                    state_nxt = IDLE;
                    clear     = 1'b1;
                    if (accept)
                        act_nxt = cfg_clamped;
                end else if (accept) begin
                    pend_nxt  = cfg_clamped;
                    state_nxt = PEND;
                end
            end
            (state == PEND): begin
                if (boundary) begin
                    act_nxt   = pending_sel;
                    clear     = 1'b1;
                    state_nxt = en ? RUN : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                clear     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            active_sel  <= RST_SEL;
            pending_sel <= '0;
        end else begin
            state       <= state_nxt;
            active_sel  <= act_nxt;
            pending_sel <= pend_nxt;
        end
    end

    clk_div_phase #(
        .CNT_W (CNT_W),
        .SEL_W (SEL_W)
    ) u_phase (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .run         (state != IDLE),
        .sel         (active_sel),
        .div_clk     (div_clk),
        .div_tick    (div_tick),
        .is_boundary (boundary)
    );

endmodule

// File: tb/tb_clk_div_sched.sv
// tb_clk_div_sched: scoreboard bench; a period-position model pushes
// expected outputs per driven cycle, popped after each rising edge.
module tb_clk_div_sched;

    localparam int CNT_W = 5;
    localparam int SEL_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             cfg_valid;
    logic [SEL_W-1:0] cfg_sel;
    logic             cfg_ready;
    logic             div_clk;
    logic             div_tick;
    logic [SEL_W-1:0] active_sel;
    logic             busy;

    always #5 clk = ~clk;

    clk_div_sched #(
        .CNT_W       (CNT_W),
        .SEL_W       (SEL_W),
        .DEFAULT_SEL (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_sel    (cfg_sel),
        .cfg_ready  (cfg_ready),
        .div_clk    (div_clk),
        .div_tick   (div_tick),
        .active_sel (active_sel),
        .busy       (busy)
    );

    typedef struct {
        int dclk;
        int tick;
        int sel;
        int busy;
        int ready;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // model: 0 idle, 1 run, 2 pend; pos = cycle index within period
    int m_state = 0;
    int m_pos   = 0;
    int m_sel   = 0;
    int m_pend  = 0;
    int m_clk   = 0;
    int m_tick  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cyc %0d: got %0d exp %0d",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic model(input int e, input int v,
                         input int s, input int r);
        int   acc, cs, half, per, bnd;
        exp_t x;
        if (r == 0) begin
            m_state = 0; m_pos = 0; m_sel = 0; m_pend = 0;
            m_clk = 0; m_tick = 0;
        end else begin
            acc  = (v != 0 && m_state != 2) ? 1 : 0;
            cs   = (s >= CNT_W) ? CNT_W - 1 : s;
            half = 1 << m_sel;
            per  = 2 * half;
            bnd  = (m_state != 0 && m_pos == per - 1) ? 1 : 0;
            if (m_state == 0) begin
                if (acc != 0) m_sel = cs;
                if (e != 0) m_state = 1;
                m_pos = 0; m_clk = 0; m_tick = 0;
            end else if (bnd != 0 && (m_state == 2 || e == 0)) begin
                if (m_state == 2) begin
                    m_sel = m_pend;
                    m_state = (e != 0) ? 1 : 0;
                end else begin
                    if (acc != 0) m_sel = cs;
                    m_state = 0;
                end
                m_pos = 0; m_clk = 0; m_tick = 0;
            end else begin
                m_pos  = (m_pos + 1) % per;
                m_clk  = (m_pos >= half) ? 1 : 0;
                m_tick = (m_pos == half) ? 1 : 0;
                if (m_state == 1 && acc != 0) begin
                    m_pend = cs;
                    m_state = 2;
                end
            end
        end
        x.dclk  = m_clk;
        x.tick  = m_tick;
        x.sel   = m_sel;
        x.busy  = (m_state != 0) ? 1 : 0;
        x.ready = (r != 0 && m_state != 2) ? 1 : 0;
        sb.push_back(x);
    endtask

    task automatic step(input int e, input int v,
                        input int s, input int r);
        exp_t x;
        rst       = r[0];
        en        = e[0];
        cfg_valid = v[0];
        cfg_sel   = SEL_W'(s);
        model(e, v, s, r);
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            x = sb.pop_front();
            chk("div_clk", int'(div_clk), x.dclk);
            chk("div_tick", int'(div_tick), x.tick);
            chk("active_sel", int'(active_sel), x.sel);
            chk("busy", int'(busy), x.busy);
            chk("cfg_ready", int'(cfg_ready), x.ready);
        end
    endtask

    task automatic run_n(input int n, input int e);
        for (int i = 0; i < n; i++) step(e, 0, 0, 1);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_sel = '0;
        // reset
        for (int i = 0; i < 3; i++) step(0, 1, 3, 0);
        // sel 0: toggle every cycle
        run_n(8, 1);
        run_n(4, 0);
        // sel 2 configured in idle, then run
        step(0, 1, 2, 1);
        run_n(19, 1);
        // ratio change mid-period
        step(1, 1, 0, 1);
        run_n(16, 1);
        // back to sel 2 then stop mid-period
        step(1, 1, 2, 1);
        run_n(13, 1);
        run_n(12, 0);
        // clamp: sel 7 -> 4
        step(0, 1, 7, 1);
        run_n(70, 1);
        // reset while pending
        step(1, 1, 1, 1);
        run_n(3, 1);
        step(1, 0, 0, 0);
        run_n(4, 0);
        // same-sel resync, then config+en together in idle
        step(1, 0, 0, 1);
        step(1, 1, 0, 1);
        run_n(6, 1);
        run_n(4, 0);
        step(1, 1, 1, 1);
        run_n(10, 1);
        // random stress
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 8) ? 1 : 0,
                 ($urandom_range(0, 5) == 0) ? 1 : 0,
                 int'($urandom_range(0, 7)),
                 ($urandom_range(0, 199) == 0) ? 0 : 1);
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
